// File: rtl/pio_out_arbiter.sv
// pio_out_arbiter
//   Round-robin write scheduler that shares one Avalon-MM output PIO among
//   NUM_REQ hardware requesters. A granted request becomes a single-cycle
//   Avalon write to PIO address 0. The arbiter then waits HOLD_CYCLES cycles,
//   so the value stays visible on the PIO out_port before the next grant.
//
//   Optional feature macro: PIO_ARB_READBACK_EN
//     When defined, a READBACK cycle follows every write. The PIO readdata is
//     compared with the written value, and any mismatch sets the sticky
//     readback_err flag (cleared by err_clr). When undefined, there is no
//     readback cycle, avm_readdata and err_clr are ignored, and readback_err
//     is tied to 0. The port list is the same in both builds.
//
// Ports
//   clk, reset_n      clock, asynchronous active-low reset
//   req_valid         per-requester write request (level)
//   req_data          requester i data at [i*DATA_W +: DATA_W]
//   req_ready         one-cycle accept pulse to the granted requester
//   avm_address       PIO address, always 0
//   avm_chipselect    PIO chipselect
//   avm_write_n       PIO write strobe, active-low
//   avm_writedata     zero-extended latched data
//   avm_readdata      PIO readdata (readback build only)
//   err_clr           clears readback_err
//   busy              arbiter is not idle
//   owner             id of the last granted requester
//   readback_err      sticky readback mismatch flag
module pio_out_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int HOLD_CYCLES = 16,
  localparam int IDW        = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [1:0]                avm_address,
  output logic                      avm_chipselect,
  output logic                      avm_write_n,
  output logic [31:0]               avm_writedata,
  input  logic [31:0]               avm_readdata,
  input  logic                      err_clr,
  output logic                      busy,
  output logic [IDW-1:0]            owner,
  output logic                      readback_err
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WRITE    = 2'd1,
    READBACK = 2'd2,
    HOLD     = 2'd3
  } state_t;

  state_t             state, next_state;
  logic [IDW-1:0]     rr_ptr, grant_id, lat_id;
  logic [IDW:0]       scan_idx;
  logic               grant_found;
  logic [DATA_W-1:0]  grant_data;
  logic [CW-1:0]      hold_cnt;
  logic               hold_done;
  logic               cs_nxt, write_n_nxt;
  logic [NUM_REQ-1:0] ready_nxt;
  logic               unused_inputs;

  assign avm_address   = 2'b00;
  assign busy          = (state != IDLE);
  assign hold_done     = (hold_cnt == CW'(HOLD_CYCLES - 1));
  assign grant_data    = req_data[grant_id*DATA_W +: DATA_W];
  assign unused_inputs = ^{avm_readdata, err_clr};

  // Scan from rr_ptr upward with wrap-around. scan_idx has one extra bit, so
  // rr_ptr + k never overflows before the wrap is applied.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    scan_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (scan_idx >= (IDW+1)'(NUM_REQ))
        scan_idx = scan_idx - (IDW+1)'(NUM_REQ);
      if (!grant_found && req_valid[scan_idx[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_id    = scan_idx[IDW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (grant_found) next_state = WRITE;
`ifdef PIO_ARB_READBACK_EN
      WRITE:    next_state = READBACK;
      READBACK: next_state = HOLD;
`else
      WRITE:    next_state = HOLD;
`endif
      HOLD:     if (hold_done) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Bus outputs are decoded from next_state and registered. They therefore
  // line up exactly with the state the FSM is in during the following cycle.
  always_comb begin
    cs_nxt      = 1'b0;
    write_n_nxt = 1'b1;
    ready_nxt   = '0;
    case (next_state)
      WRITE: begin
        cs_nxt              = 1'b1;
        write_n_nxt         = 1'b0;
        ready_nxt[grant_id] = 1'b1;
      end
      READBACK: cs_nxt = 1'b1;
      default: ;
    endcase
  end

  // Data is latched on the IDLE-cycle grant, so later requester changes are
  // ignored. The pointer moves past the winner once the write has issued.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_writedata  <= '0;
      req_ready      <= '0;
      lat_id         <= '0;
      owner          <= '0;
      rr_ptr         <= '0;
      hold_cnt       <= '0;
    end else begin
      avm_chipselect <= cs_nxt;
      avm_write_n    <= write_n_nxt;
      req_ready      <= ready_nxt;
      if (state == IDLE && grant_found) begin
        lat_id        <= grant_id;
        avm_writedata <= 32'(grant_data);
      end
      if (state == WRITE) begin
        owner  <= lat_id;
        rr_ptr <= (lat_id == IDW'(NUM_REQ - 1)) ? '0 : lat_id + 1'b1;
      end
      if (state != HOLD)
        hold_cnt <= '0;
      else if (!hold_done)
        hold_cnt <= hold_cnt + 1'b1;
    end
  end

`ifdef PIO_ARB_READBACK_EN
  // A mismatch takes priority over a clear in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      readback_err <= 1'b0;
    else if (state == READBACK && avm_readdata[DATA_W-1:0] != avm_writedata[DATA_W-1:0])
      readback_err <= 1'b1;
    else if (err_clr)
      readback_err <= 1'b0;
  end
`else
  assign readback_err = 1'b0;
`endif

endmodule

// File: tb/tb_pio_out_arbiter.sv
// tb_pio_out_arbiter
//   Drives pio_out_arbiter (NUM_REQ=4, DATA_W=8, HOLD_CYCLES=4) together with
//   a small model of an 8-bit Avalon output PIO. Expected grants come from a
//   round-robin reference function working on the request mask and a pointer.
module tb_pio_out_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int HOLD    = 4;
`ifdef PIO_ARB_READBACK_EN
  localparam int GAP     = HOLD + 3;
  localparam bit RB_EN   = 1'b1;
`else
  localparam int GAP     = HOLD + 2;
  localparam bit RB_EN   = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic [1:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        err_clr = 1'b0;
  logic        busy;
  logic [1:0]  owner;
  logic        readback_err;

  logic [7:0]  out_port;
  logic        force_rd_zero = 1'b0;

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int exp_writes = 0;
  int rr_model = 0;
  int g;
  logic [31:0] rnd_data;
  logic [3:0]  rnd_mask;

  int          wr_cycle[$];
  logic [31:0] wr_data[$];
  logic [3:0]  wr_ready[$];

  pio_out_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .DATA_W     (DATA_W),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .avm_address   (avm_address),
    .avm_chipselect(avm_chipselect),
    .avm_write_n   (avm_write_n),
    .avm_writedata (avm_writedata),
    .avm_readdata  (avm_readdata),
    .err_clr       (err_clr),
    .busy          (busy),
    .owner         (owner),
    .readback_err  (readback_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // 8-bit output PIO slave: data register at address 0, combinational readdata
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      out_port <= 8'h00;
    else if (avm_chipselect && !avm_write_n && avm_address == 2'b00)
      out_port <= avm_writedata[7:0];
  end
  assign avm_readdata = force_rd_zero ? 32'h0 : {24'h0, out_port};

  // Log every write strobe seen on the bus
  always @(negedge clk) begin
    if (avm_chipselect && !avm_write_n) begin
      wr_cycle.push_back(cycle);
      wr_data.push_back(avm_writedata);
      wr_ready.push_back(req_ready);
    end
  end

  // Reference round-robin: first requester at or after ptr, with wrap
  function automatic int predictGrant(input logic [3:0] mask, input int ptr);
    for (int k = 0; k < NUM_REQ; k++)
      if (mask[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
    return -1;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [3:0] v, input logic [31:0] d);
    req_valid = v;
    req_data  = d;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic waitWrites(input int target, input int budget);
    int n = 0;
    while (wr_data.size() < target && n < budget) begin
      step(1);
      n++;
    end
    checkOutput("write_count", wr_data.size(), target);
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      step(1);
      n++;
    end
    checkOutput("busy_idle", {31'h0, busy}, 32'h0);
  endtask

  task automatic expectWrite(input string tag, input int gid, input logic [7:0] d);
    exp_writes++;
    waitWrites(exp_writes, 3 * GAP);
    checkOutput({tag, "_data"}, wr_data[exp_writes-1], {24'h0, d});
    checkOutput({tag, "_ready"}, {28'h0, wr_ready[exp_writes-1]}, 32'(1 << gid));
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    applyStimulus(4'b0000, 32'h0);
    err_clr = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(1);
    rr_model = 0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cycle);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Reset state
    step(2);
    checkOutput("rst_busy", {31'h0, busy}, 32'h0);
    checkOutput("rst_owner", {30'h0, owner}, 32'h0);
    checkOutput("rst_cs", {31'h0, avm_chipselect}, 32'h0);
    checkOutput("rst_write_n", {31'h0, avm_write_n}, 32'h1);
    checkOutput("rst_wdata", avm_writedata, 32'h0);
    checkOutput("rst_addr", {30'h0, avm_address}, 32'h0);
    checkOutput("rst_ready", {28'h0, req_ready}, 32'h0);
    checkOutput("rst_err", {31'h0, readback_err}, 32'h0);
    reset_n = 1'b1;
    step(1);

    // 1: single request from requester 1
    applyStimulus(4'b0010, 32'h0000A500);
    g = predictGrant(4'b0010, rr_model);
    expectWrite("t1", g, 8'hA5);
    checkOutput("t1_cs", {31'h0, avm_chipselect}, 32'h1);
    checkOutput("t1_write_n", {31'h0, avm_write_n}, 32'h0);
    checkOutput("t1_addr", {30'h0, avm_address}, 32'h0);
    checkOutput("t1_wdata", avm_writedata, 32'h000000A5);
    applyStimulus(4'b0000, 32'h0);
    rr_model = (g + 1) % NUM_REQ;
    step(1);
    checkOutput("t1_out_port", {24'h0, out_port}, 32'hA5);
    checkOutput("t1_owner", {30'h0, owner}, 32'(g));
    checkOutput("t1_ready_pulse", {28'h0, req_ready}, 32'h0);
    step(GAP - 3);
    checkOutput("t1_busy_hold", {31'h0, busy}, 32'h1);
    step(1);
    checkOutput("t1_busy_end", {31'h0, busy}, 32'h0);

    // 2: all four requesters held valid
    doReset();
    applyStimulus(4'b1111, 32'h13121110);
    for (int i = 0; i < 5; i++) begin
      g = predictGrant(4'b1111, rr_model);
      expectWrite("t2", g, 8'h10 + 8'(g));
      if (i > 0)
        checkOutput("t2_gap", wr_cycle[exp_writes-1] - wr_cycle[exp_writes-2], GAP);
      rr_model = (g + 1) % NUM_REQ;
    end
    applyStimulus(4'b0000, 32'h0);
    waitIdle(3 * GAP);

    // 3: requester 3 raised one cycle after a write by requester 0
    applyStimulus(4'b0001, 32'h00000021);
    g = predictGrant(4'b0001, rr_model);
    expectWrite("t3a", g, 8'h21);
    rr_model = (g + 1) % NUM_REQ;
    applyStimulus(4'b0000, 32'h0);
    step(1);
    applyStimulus(4'b1000, 32'h33000000);
    g = predictGrant(4'b1000, rr_model);
    expectWrite("t3b", g, 8'h33);
    checkOutput("t3_gap", wr_cycle[exp_writes-1] - wr_cycle[exp_writes-2], GAP);
    rr_model = (g + 1) % NUM_REQ;
    applyStimulus(4'b0000, 32'h0);
    waitIdle(3 * GAP);

    // 4: reset mid-hold, then requesters 2 and 3 together
    applyStimulus(4'b0100, 32'h00440000);
    g = predictGrant(4'b0100, rr_model);
    expectWrite("t4a", g, 8'h44);
    applyStimulus(4'b0000, 32'h0);
    step(2);
    reset_n = 1'b0;
    #1;
    checkOutput("t4_rst_busy", {31'h0, busy}, 32'h0);
    checkOutput("t4_rst_cs", {31'h0, avm_chipselect}, 32'h0);
    checkOutput("t4_rst_write_n", {31'h0, avm_write_n}, 32'h1);
    checkOutput("t4_rst_out_port", {24'h0, out_port}, 32'h0);
    checkOutput("t4_rst_owner", {30'h0, owner}, 32'h0);
    step(1);
    reset_n = 1'b1;
    rr_model = 0;
    step(1);
    applyStimulus(4'b1100, 32'h53520000);
    g = predictGrant(4'b1100, rr_model);
    expectWrite("t4b", g, 8'h52);
    rr_model = (g + 1) % NUM_REQ;
    applyStimulus(4'b1000, 32'h53520000);
    g = predictGrant(4'b1000, rr_model);
    expectWrite("t4c", g, 8'h53);
    rr_model = (g + 1) % NUM_REQ;
    applyStimulus(4'b0000, 32'h0);
    waitIdle(3 * GAP);

    // 6: requester 0 withdraws during hold before being granted
    applyStimulus(4'b0010, 32'h00006100);
    g = predictGrant(4'b0010, rr_model);
    expectWrite("t6", g, 8'h61);
    rr_model = (g + 1) % NUM_REQ;
    applyStimulus(4'b0001, 32'h00000066);
    step(2);
    applyStimulus(4'b0000, 32'h0);
    waitIdle(3 * GAP);
    step(3);
    checkOutput("t6_no_write", wr_data.size(), exp_writes);
    checkOutput("t6_busy", {31'h0, busy}, 32'h0);
    checkOutput("t6_out_port", {24'h0, out_port}, 32'h61);

    // 5: forced bad readback, sticky flag, then clear
    force_rd_zero = 1'b1;
    applyStimulus(4'b0100, 32'h003C0000);
    g = predictGrant(4'b0100, rr_model);
    expectWrite("t5a", g, 8'h3C);
    rr_model = (g + 1) % NUM_REQ;
    applyStimulus(4'b0000, 32'h0);
    waitIdle(3 * GAP);
    force_rd_zero = 1'b0;
    checkOutput("t5_err_set", {31'h0, readback_err}, {31'h0, RB_EN});
    applyStimulus(4'b1000, 32'h3D000000);
    g = predictGrant(4'b1000, rr_model);
    expectWrite("t5b", g, 8'h3D);
    rr_model = (g + 1) % NUM_REQ;
    applyStimulus(4'b0000, 32'h0);
    waitIdle(3 * GAP);
    checkOutput("t5_err_sticky", {31'h0, readback_err}, {31'h0, RB_EN});
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    step(1);
    checkOutput("t5_err_clr", {31'h0, readback_err}, 32'h0);

    // Randomized rounds against the reference arbiter
    for (int r = 0; r < 16; r++) begin
      rnd_mask = 4'($urandom_range(1, 15));
      rnd_data = $urandom();
      applyStimulus(rnd_mask, rnd_data);
      g = predictGrant(rnd_mask, rr_model);
      expectWrite("rnd", g, rnd_data[g*8 +: 8]);
      rr_model = (g + 1) % NUM_REQ;
      applyStimulus(4'b0000, 32'h0);
      waitIdle(3 * GAP);
      checkOutput("rnd_owner", {30'h0, owner}, 32'(g));
      checkOutput("rnd_out_port", {24'h0, out_port}, {24'h0, rnd_data[g*8 +: 8]});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
